// File: rtl/cnt_diff_monitor.sv
// Watches a pair of counters for divergence, captures the first diverging values and reports
// each divergence's length as an event over a valid/ack handshake, with sticky alarm/lost flags.
module cnt_diff_monitor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RUN_W  = 16,
  parameter int unsigned THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt1,
  input  logic [WIDTH-1:0] cnt2,
  input  logic             ack,
  output logic             valid,
  output logic [WIDTH-1:0] cap_cnt1,
  output logic [WIDTH-1:0] cap_cnt2,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] evt_cnt,
  output logic             mismatch,
  output logic             alarm,
  output logic             lost
);

  localparam logic [RUN_W-1:0] RunMax  = '1;
  localparam logic [RUN_W-1:0] ThreshV = RUN_W'(THRESH);
  localparam logic [RUN_W-1:0] RunOne  = RUN_W'(1);

  typedef enum logic [1:0] {StIdle, StWatch, StRun, StReport} state_e;

  state_e           state_q;
  logic             m;
  logic [RUN_W-1:0] run_inc;

  assign m       = en & (cnt1 != cnt2);
  assign run_inc = (run_len == RunMax) ? run_len : run_len + RunOne;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      valid    <= 1'b0;
      cap_cnt1 <= '0;
      cap_cnt2 <= '0;
      run_len  <= '0;
      evt_cnt  <= '0;
      mismatch <= 1'b0;
      alarm    <= 1'b0;
      lost     <= 1'b0;
    end else begin
      mismatch <= m;
      unique case (state_q)
        StIdle: begin
          if (en) state_q <= StWatch;
        end
        StWatch: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (m) begin
            state_q  <= StRun;
            cap_cnt1 <= cnt1;
            cap_cnt2 <= cnt2;
            run_len  <= RunOne;
            if (ThreshV == RunOne) alarm <= 1'b1;
          end
        end
        StRun: begin
          // Dropping enable abandons the run; captured values are left as they were.
          if (!en) begin
            state_q <= StIdle;
          end else if (m) begin
            run_len <= run_inc;
            if (run_inc == ThreshV) alarm <= 1'b1;
          end else begin
            state_q <= StReport;
            valid   <= 1'b1;
            if (evt_cnt != RunMax) evt_cnt <= evt_cnt + RunOne;
          end
        end
        StReport: begin
          // A pending report always completes; any new divergence meanwhile is only flagged.
          if (m) lost <= 1'b1;
          if (ack) begin
            state_q <= StWatch;
            valid   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_diff_monitor.sv
// Directed and randomized checks of cnt_diff_monitor against an event-level reference model.
module tb_cnt_diff_monitor;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned RUN_W  = 16;
  localparam int unsigned THRESH = 4;
  localparam int          RunMax = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] cnt1 = '0;
  logic [WIDTH-1:0] cnt2 = '0;
  logic             valid, mismatch, alarm, lost;
  logic [WIDTH-1:0] cap_cnt1, cap_cnt2;
  logic [RUN_W-1:0] run_len, evt_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit do_check = 1'b1;

  // Reference model: phase flags plus an unbounded run counter.
  bit          m_watch, m_run, m_pend, m_mis, m_alarm, m_lost;
  int          m_len, m_evt;
  logic [31:0] m_cap1, m_cap2;

  cnt_diff_monitor #(
    .WIDTH (WIDTH),
    .RUN_W (RUN_W),
    .THRESH(THRESH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .ack     (ack),
    .valid   (valid),
    .cap_cnt1(cap_cnt1),
    .cap_cnt2(cap_cnt2),
    .run_len (run_len),
    .evt_cnt (evt_cnt),
    .mismatch(mismatch),
    .alarm   (alarm),
    .lost    (lost)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit m;
    m = en && (cnt1 != cnt2);
    if (rst) begin
      m_watch = 0; m_run = 0; m_pend = 0; m_mis = 0; m_alarm = 0; m_lost = 0;
      m_len = 0; m_evt = 0; m_cap1 = 0; m_cap2 = 0;
    end else begin
      m_mis = m;
      if (m_pend) begin
        if (m) m_lost = 1;
        if (ack) begin
          m_pend  = 0;
          m_watch = 1;
        end
      end else if (m_run) begin
        if (!en) begin
          m_run   = 0;
          m_watch = 0;
        end else if (m) begin
          m_len++;
          if (m_len >= int'(THRESH)) m_alarm = 1;
        end else begin
          m_run  = 0;
          m_pend = 1;
          if (m_evt < RunMax) m_evt++;
        end
      end else if (m_watch) begin
        if (!en) begin
          m_watch = 0;
        end else if (m) begin
          m_watch = 0;
          m_run   = 1;
          m_len   = 1;
          m_cap1  = cnt1;
          m_cap2  = cnt2;
          if (int'(THRESH) <= 1) m_alarm = 1;
        end
      end else if (en) begin
        m_watch = 1;
      end
    end
  endtask

  task automatic check_model();
    int len_exp;
    len_exp = (m_len > RunMax) ? RunMax : m_len;
    expect_eq("valid", 64'(valid), 64'(m_pend));
    expect_eq("cap_cnt1", 64'(cap_cnt1), 64'(m_cap1));
    expect_eq("cap_cnt2", 64'(cap_cnt2), 64'(m_cap2));
    expect_eq("run_len", 64'(run_len), 64'(len_exp));
    expect_eq("evt_cnt", 64'(evt_cnt), 64'(m_evt));
    expect_eq("mismatch", 64'(mismatch), 64'(m_mis));
    expect_eq("alarm", 64'(alarm), 64'(m_alarm));
    expect_eq("lost", 64'(lost), 64'(m_lost));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (do_check) check_model();
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    cnt1 = a;
    cnt2 = b;
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_all_zero(input string tag);
    expect_eq({tag, "_valid"}, 64'(valid), 64'd0);
    expect_eq({tag, "_cap1"}, 64'(cap_cnt1), 64'd0);
    expect_eq({tag, "_cap2"}, 64'(cap_cnt2), 64'd0);
    expect_eq({tag, "_run_len"}, 64'(run_len), 64'd0);
    expect_eq({tag, "_evt_cnt"}, 64'(evt_cnt), 64'd0);
    expect_eq({tag, "_mismatch"}, 64'(mismatch), 64'd0);
    expect_eq({tag, "_alarm"}, 64'(alarm), 64'd0);
    expect_eq({tag, "_lost"}, 64'(lost), 64'd0);
  endtask

  initial begin
    logic [31:0] base;
    bit          div;

    // Reset held with diverged counters and enable high.
    rst = 1'b1; en = 1'b1;
    drive(32'd5, 32'd9);
    drive(32'd6, 32'd10);
    expect_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(32'd100 + 32'(i), 32'd100 + 32'(i));
    expect_eq("idle_valid", 64'(valid), 64'd0);
    expect_eq("idle_evt", 64'(evt_cnt), 64'd0);

    // Single three-cycle event.
    drive(32'h0B, 32'h0C);
    drive(32'h0C, 32'h0D);
    drive(32'h0D, 32'h0E);
    drive(32'h0F, 32'h0F);
    expect_eq("single_valid", 64'(valid), 64'd1);
    expect_eq("single_cap1", 64'(cap_cnt1), 64'h0B);
    expect_eq("single_cap2", 64'(cap_cnt2), 64'h0C);
    expect_eq("single_run_len", 64'(run_len), 64'd3);
    expect_eq("single_evt", 64'(evt_cnt), 64'd1);
    expect_eq("single_alarm", 64'(alarm), 64'd0);
    for (int i = 0; i < 5; i++) drive(32'h10 + 32'(i), 32'h10 + 32'(i));
    expect_eq("hold_valid", 64'(valid), 64'd1);
    expect_eq("hold_run_len", 64'(run_len), 64'd3);
    ack = 1'b1;
    drive(32'h20, 32'h20);
    ack = 1'b0;
    expect_eq("ack_valid", 64'(valid), 64'd0);

    // Divergence while an event is pending.
    reset_dut();
    drive(32'h1F, 32'h1F);
    drive(32'h20, 32'h21);
    drive(32'h21, 32'h22);
    drive(32'h23, 32'h23);
    drive(32'h50, 32'h60);
    drive(32'h51, 32'h61);
    expect_eq("lost_flag", 64'(lost), 64'd1);
    expect_eq("lost_cap1", 64'(cap_cnt1), 64'h20);
    expect_eq("lost_cap2", 64'(cap_cnt2), 64'h21);
    expect_eq("lost_run_len", 64'(run_len), 64'd2);
    ack = 1'b1;
    drive(32'h52, 32'h52);
    ack = 1'b0;
    drive(32'h70, 32'h71);
    drive(32'h72, 32'h72);
    expect_eq("next_valid", 64'(valid), 64'd1);
    expect_eq("next_cap1", 64'(cap_cnt1), 64'h70);
    expect_eq("next_evt", 64'(evt_cnt), 64'd2);
    ack = 1'b1;
    drive(32'h73, 32'h73);
    ack = 1'b0;

    // Enable dropped mid-run, then during a report.
    reset_dut();
    drive(32'h1, 32'h1);
    drive(32'h2, 32'h3);
    en = 1'b0;
    drive(32'h3, 32'h4);
    expect_eq("endrop_valid", 64'(valid), 64'd0);
    expect_eq("endrop_evt", 64'(evt_cnt), 64'd0);
    expect_eq("endrop_run_len", 64'(run_len), 64'd1);
    en = 1'b1;
    drive(32'h5, 32'h5);
    drive(32'h6, 32'h7);
    drive(32'h8, 32'h8);
    en = 1'b0;
    for (int i = 0; i < 3; i++) drive(32'h9 + 32'(i), 32'hA0 + 32'(i));
    expect_eq("enrep_valid", 64'(valid), 64'd1);
    expect_eq("enrep_evt", 64'(evt_cnt), 64'd1);
    ack = 1'b1;
    drive(32'hC, 32'hC);
    ack = 1'b0;
    en = 1'b1;
    expect_eq("enrep_ack", 64'(valid), 64'd0);

    // Reset while reporting, with alarm and lost both set.
    reset_dut();
    drive(32'h1, 32'h1);
    for (int i = 0; i < 5; i++) drive(32'h40 + 32'(i), 32'h80 + 32'(i));
    drive(32'h9, 32'h9);
    drive(32'hA, 32'hB);
    expect_eq("pre_rst_alarm", 64'(alarm), 64'd1);
    expect_eq("pre_rst_lost", 64'(lost), 64'd1);
    expect_eq("pre_rst_valid", 64'(valid), 64'd1);
    rst = 1'b1;
    drive(32'hC, 32'hD);
    expect_all_zero("midrep_reset");
    rst = 1'b0;

    // Long divergence saturating the run length.
    reset_dut();
    drive(32'd10, 32'd10);
    cnt1 = 32'd0;
    cnt2 = 32'd11;
    for (int i = 0; i < 70000; i++) begin
      do_check = (i < 8) || (i % 4096 == 0);
      tick();
      if (i == 2) expect_eq("alarm_before", 64'(alarm), 64'd0);
      if (i == 3) expect_eq("alarm_at_thresh", 64'(alarm), 64'd1);
      cnt1++;
      cnt2++;
    end
    do_check = 1'b1;
    check_model();
    expect_eq("sat_run_len", 64'(run_len), 64'hFFFF);
    expect_eq("sat_alarm", 64'(alarm), 64'd1);
    expect_eq("sat_valid", 64'(valid), 64'd0);
    drive(32'h5, 32'h5);
    expect_eq("sat_report", 64'(valid), 64'd1);
    expect_eq("sat_report_len", 64'(run_len), 64'hFFFF);
    ack = 1'b1;
    drive(32'h6, 32'h6);
    ack = 1'b0;

    // Randomized traffic.
    reset_dut();
    base = 32'h1000;
    div  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(199) == 0);
      en  = ($urandom_range(9) != 0);
      ack = ($urandom_range(2) == 0);
      if ($urandom_range(3) == 0) div = ~div;
      cnt2 = base;
      cnt1 = div ? (base ^ (32'h1 << $urandom_range(31))) : base;
      tick();
      base = base + 32'(1 + $urandom_range(3));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_diff_monitor.md
# cnt_diff_monitor

Downstream consumer of the dual 32-bit counter pair. Compares `cnt1` and `cnt2` every cycle and captures the values at the start of each divergence. Measures how long each divergence lasts and reports it as an event over a valid/ack handshake. Keeps sticky alarm and lost-event flags for the bring-up bench and for later on-chip debug.

## Interface
Parameters:
- `WIDTH`, 32: counter width compared.
- `RUN_W`, 16: width of run-length and event counters.
- `THRESH`, 4: run length (cycles) at which `alarm` sets; must satisfy 1 ≤ THRESH ≤ 2^RUN_W−1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  monitor enable.
- `cnt1`  in  WIDTH  counter 1 value.
- `cnt2`  in  WIDTH  counter 2 value.
- `ack`  in  1  consumer accepts current event.
- `valid`  out  1  event report pending.
- `cap_cnt1`  out  WIDTH  `cnt1` at first mismatching cycle of event.
- `cap_cnt2`  out  WIDTH  `cnt2` at first mismatching cycle of event.
- `run_len`  out  RUN_W  mismatching cycles in event (live while running, frozen while reporting).
- `evt_cnt`  out  RUN_W  completed events, saturating.
- `mismatch`  out  1  registered (cnt1 != cnt2) from previous cycle, gated by `en`.
- `alarm`  out  1  sticky: some event reached THRESH cycles.
- `lost`  out  1  sticky: mismatch seen while an event was pending.

## Operation
- Clock `clk`; reset `rst` is synchronous and active-high.
- Raw compare `m = en & (cnt1 != cnt2)`, full WIDTH, unsigned equality only.
- FSM states: IDLE, WATCH, RUN, REPORT.
- IDLE: entered on reset. `en`=1 → WATCH.
- WATCH: `en`=0 → IDLE. `m`=1 → RUN. On that edge: `cap_cnt1<=cnt1`, `cap_cnt2<=cnt2`, `run_len<=1`.
- RUN:
  - `m`=1 → stay, `run_len` increments, saturating at 2^RUN_W−1.
  - `m`=0 with `en`=1 → REPORT, `valid<=1`, `evt_cnt` increments (saturating).
  - `en`=0 → IDLE. The run is discarded with no report and no `evt_cnt` change; `cap_*` and `run_len` keep their last values.
- REPORT: `valid`=1 and `cap_*`/`run_len` frozen. `ack`=1 → WATCH, `valid<=0`. The `en` value is ignored; an event in REPORT always completes. `m`=1 while in REPORT sets `lost`, and that mismatch is not captured.
- `alarm` sets on the edge where `run_len` becomes THRESH (or `run_len<=1` with THRESH=1). Only reset clears it.
- `ack` outside REPORT is ignored.
- Reset values: state IDLE, `valid`=0, `cap_cnt1`=`cap_cnt2`=0, `run_len`=0, `evt_cnt`=0, `mismatch`=0, `alarm`=0, `lost`=0. Reset overrides all other inputs in the same cycle. Reset mid-RUN or mid-REPORT drops the event silently.

## Timing
- `mismatch` lags the inputs by 1 cycle.
- First mismatching input cycle at edge N → `cap_*` and `run_len`=1 visible after edge N.
- Event of L mismatching cycles followed by first match at edge N+L → `valid`=1 after edge N+L, with `run_len`=L.
- `ack` high at edge with `valid`=1 → `valid`=0 after that edge. Back-to-back events are possible: a new mismatch is capturable from the cycle after the ack edge (WATCH).
- Minimum event-to-event spacing: mismatch, match, ack = 3 edges.
- Each output is a flop (no combinational input-to-output path).

## Test plan
- Reset: `rst`=1 for 2 cycles with `cnt1`≠`cnt2` and `en`=1 → all outputs 0 and state IDLE. After release with equal counters for 10 cycles → `valid`=0, `evt_cnt`=0.
- Single event: equal counters, then `cnt1`=0x0B / `cnt2`=0x0C for 3 cycles (both incrementing), then equal → `valid`=1 with `cap_cnt1`=0x0B, `cap_cnt2`=0x0C, `run_len`=3, `evt_cnt`=1, `alarm`=0. Hold `ack`=0 for 5 cycles → outputs stable. Pulse `ack` → `valid`=0 next cycle.
- Counter-1 reset divergence: `cnt1` forced to 0 at `cnt2`=11, stays diverged for 70000 cycles → `run_len` saturates at 0xFFFF, `alarm`=1 after 4th mismatching cycle, `valid`=0 throughout.
- Lost event: event pending with `ack`=0, then 2 mismatching cycles → `lost`=1, `cap_*` unchanged. After `ack`, the next mismatch is captured normally and `evt_cnt`=2.
- Enable drop: `en`=0 in the 2nd cycle of a run → IDLE with no `valid` and `evt_cnt` unchanged. `en`=0 during REPORT → `valid` held until `ack`.
- Reset mid-REPORT: `rst`=1 while `valid`=1 → all outputs 0 next cycle, including `alarm` and `lost`.
